// File: rtl/pwm_timer_core_if.sv
// Register-field bundle between the PWM register slave and the timer core.
// The register side drives the configuration; the core returns the waveform and status.
interface pwm_timer_core_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PSC_W = 5
);
  logic [CNT_W-1:0] pr_in;
  logic [CNT_W-1:0] duty_cycle_in;
  logic [PSC_W-1:0] prescale_value;
  logic             en_prescalar;
  logic             EN_TMR;
  logic             soft_rst;
  logic             pwm_out;
  logic             period_tick;
  logic [CNT_W-1:0] cnt_out;

  modport master (
    output pr_in, duty_cycle_in, prescale_value, en_prescalar, EN_TMR, soft_rst,
    input  pwm_out, period_tick, cnt_out
  );

  modport slave (
    input  pr_in, duty_cycle_in, prescale_value, en_prescalar, EN_TMR, soft_rst,
    output pwm_out, period_tick, cnt_out
  );
endinterface

// File: rtl/pwm_timer_core.sv
// PWM timer: prescaler, up-counter and registered compare output.
// Period, duty and prescale are shadowed so software writes only land at a period wrap.
module pwm_timer_core #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PSC_W = 5
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  pwm_timer_core_if.slave   bus
);

  logic [CNT_W-1:0] pr_sh;
  logic [CNT_W-1:0] duty_sh;
  logic [PSC_W-1:0] psc_sh;
  logic [PSC_W-1:0] psc_cnt;
  logic [CNT_W-1:0] cnt;
  logic             pwm_q;
  logic             tick_q;

  logic             run_c;
  logic             tick_c;
  logic             wrap_c;
  logic             load_c;
  logic [PSC_W-1:0] psc_nxt_c;
  logic [CNT_W-1:0] cnt_nxt_c;
  logic             pwm_nxt_c;

  // Next-state logic for prescaler, counter, shadows and compare.
  always_comb begin
    run_c     = bus.EN_TMR & ~bus.soft_rst;
    tick_c    = bus.en_prescalar ? (psc_cnt == psc_sh) : 1'b1;
    wrap_c    = run_c & tick_c & (cnt == pr_sh);
    load_c    = ~run_c | wrap_c;
    psc_nxt_c = '0;
    cnt_nxt_c = cnt;
    pwm_nxt_c = run_c & (cnt < duty_sh);

    // Prescaler only free-runs while enabled and running; any tick restarts it.
    if (run_c && bus.en_prescalar && !tick_c) begin
      psc_nxt_c = psc_cnt + PSC_W'(1);
    end

    if (!run_c || wrap_c) begin
      cnt_nxt_c = '0;
    end else if (tick_c) begin
      cnt_nxt_c = cnt + CNT_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pr_sh   <= '0;
      duty_sh <= '0;
      psc_sh  <= '0;
      psc_cnt <= '0;
      cnt     <= '0;
      pwm_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      psc_cnt <= psc_nxt_c;
      cnt     <= cnt_nxt_c;
      pwm_q   <= pwm_nxt_c;
      tick_q  <= wrap_c;
      if (load_c) begin
        pr_sh   <= bus.pr_in;
        duty_sh <= bus.duty_cycle_in;
        psc_sh  <= bus.prescale_value;
      end
    end
  end

  assign bus.cnt_out     = cnt;
  assign bus.pwm_out     = pwm_q;
  assign bus.period_tick = tick_q;

endmodule

// File: tb/tb_pwm_timer_core.sv
// Self-checking bench for pwm_timer_core: directed scenarios plus randomized traffic,
// all compared cycle-by-cycle against a period/position arithmetic model.
module tb_pwm_timer_core;

  logic PCLK;
  logic PRESETn;
  int   checks;
  int   errors;

  // Reference model: position in PCLKs within the current period.
  int unsigned m_pos;
  logic [15:0] m_pr, m_duty, m_cnt;
  logic [4:0]  m_psc;
  logic        m_en_prev, m_pwm, m_tick;

  pwm_timer_core_if #(.CNT_W(16), .PSC_W(5)) bus ();

  pwm_timer_core #(.CNT_W(16), .PSC_W(5)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic model_zero();
    m_pos = 0; m_pr = '0; m_duty = '0; m_psc = '0; m_cnt = '0;
    m_en_prev = 1'b0; m_pwm = 1'b0; m_tick = 1'b0;
  endtask

  // One rising edge: model consumes the same inputs the DUT samples, then move to the falling edge.
  task automatic step();
    int unsigned div, len;
    @(posedge PCLK);
    if (!PRESETn) begin
      model_zero();
    end else if (!bus.EN_TMR || bus.soft_rst) begin
      m_pos = 0; m_cnt = '0; m_pwm = 1'b0; m_tick = 1'b0;
      m_pr = bus.pr_in; m_duty = bus.duty_cycle_in; m_psc = bus.prescale_value;
      m_en_prev = bus.en_prescalar;
    end else begin
      div = bus.en_prescalar ? 32'(m_psc) + 1 : 1;
      if (bus.en_prescalar != m_en_prev) m_pos = 32'(m_cnt) * div;
      m_pwm  = (m_cnt < m_duty);
      len    = (32'(m_pr) + 1) * div;
      m_pos  = m_pos + 1;
      m_tick = 1'b0;
      if (m_pos == len) begin
        m_pos = 0; m_tick = 1'b1;
        m_pr = bus.pr_in; m_duty = bus.duty_cycle_in; m_psc = bus.prescale_value;
      end
      m_cnt = 16'(m_pos / div);
      m_en_prev = bus.en_prescalar;
    end
    @(negedge PCLK);
  endtask

  task automatic set_cfg(input logic [15:0] pr, input logic [15:0] duty,
                         input logic [4:0] psc, input logic enp);
    bus.pr_in = pr; bus.duty_cycle_in = duty; bus.prescale_value = psc; bus.en_prescalar = enp;
  endtask

  task automatic stop_and_load(input logic [15:0] pr, input logic [15:0] duty,
                               input logic [4:0] psc, input logic enp);
    bus.EN_TMR = 1'b0; bus.soft_rst = 1'b0;
    set_cfg(pr, duty, psc, enp);
    step(); step();
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; bus.EN_TMR = 1'b1; bus.soft_rst = 1'b0;
    set_cfg(16'd9, 16'd3, 5'd0, 1'b0);
    model_zero();
    step(); step();
    checks++;
    if ({bus.cnt_out, bus.pwm_out, bus.period_tick} !== {16'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got cnt=%0d pwm=%b tick=%b, want 0 0 0", bus.cnt_out, bus.pwm_out, bus.period_tick);
    end
    bus.EN_TMR = 1'b0;
    PRESETn = 1'b1;
    step();
  endtask

  task automatic test_no_prescale();
    int highs = 0, ticks = 0;
    logic [15:0] maxc = '0;
    stop_and_load(16'd9, 16'd3, 5'd0, 1'b0);
    bus.EN_TMR = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      checks++;
      if ({bus.cnt_out, bus.pwm_out, bus.period_tick} !== {m_cnt, m_pwm, m_tick}) begin
        errors++;
        $display("FAIL no_prescale cyc %0d: got %0d/%b/%b want %0d/%b/%b", i,
                 bus.cnt_out, bus.pwm_out, bus.period_tick, m_cnt, m_pwm, m_tick);
      end
      if (i >= 2) begin
        highs += int'(bus.pwm_out); ticks += int'(bus.period_tick);
        if (bus.cnt_out > maxc) maxc = bus.cnt_out;
      end
    end
    checks++;
    if (highs != 9 || ticks != 3 || maxc != 16'd9) begin
      errors++;
      $display("FAIL no_prescale_shape: got highs=%0d ticks=%0d max=%0d want 9 3 9", highs, ticks, maxc);
    end
  endtask

  task automatic test_divide2();
    int highs = 0, ticks = 0;
    stop_and_load(16'd9, 16'd3, 5'd1, 1'b1);
    bus.EN_TMR = 1'b1;
    for (int i = 0; i < 62; i++) begin
      step();
      checks++;
      if ({bus.cnt_out, bus.pwm_out, bus.period_tick} !== {m_cnt, m_pwm, m_tick}) begin
        errors++;
        $display("FAIL divide2 cyc %0d: got %0d/%b/%b want %0d/%b/%b", i,
                 bus.cnt_out, bus.pwm_out, bus.period_tick, m_cnt, m_pwm, m_tick);
      end
      if (i >= 2) begin highs += int'(bus.pwm_out); ticks += int'(bus.period_tick); end
    end
    checks++;
    if (highs != 18 || ticks != 3) begin
      errors++;
      $display("FAIL divide2_shape: got highs=%0d ticks=%0d want 18 3", highs, ticks);
    end
  endtask

  task automatic test_shadowing();
    int n = 0, highs = 0;
    stop_and_load(16'd9, 16'd3, 5'd0, 1'b0);
    bus.EN_TMR = 1'b1;
    step(); step();
    while (bus.cnt_out != 16'd5 && n < 40) begin step(); n++; end
    bus.duty_cycle_in = 16'd7;
    n = 0;
    while (bus.period_tick !== 1'b1 && n < 40) begin
      step(); n++;
      checks++;
      if ({bus.cnt_out, bus.pwm_out, bus.period_tick} !== {m_cnt, m_pwm, m_tick}) begin
        errors++;
        $display("FAIL shadow_hold: got %0d/%b/%b want %0d/%b/%b",
                 bus.cnt_out, bus.pwm_out, bus.period_tick, m_cnt, m_pwm, m_tick);
      end
    end
    highs = int'(bus.pwm_out);
    for (int i = 0; i < 9; i++) begin
      step();
      highs += int'(bus.pwm_out);
      checks++;
      if ({bus.cnt_out, bus.pwm_out, bus.period_tick} !== {m_cnt, m_pwm, m_tick}) begin
        errors++;
        $display("FAIL shadow_apply: got %0d/%b/%b want %0d/%b/%b",
                 bus.cnt_out, bus.pwm_out, bus.period_tick, m_cnt, m_pwm, m_tick);
      end
    end
    checks++;
    if (highs != 7) begin
      errors++;
      $display("FAIL shadow_duty: got highs=%0d want 7 (timeout cycles %0d)", highs, n);
    end
  endtask

  task automatic test_extremes();
    logic [15:0] prs [3]   = '{16'd9, 16'd9, 16'd0};
    logic [15:0] duties [3] = '{16'd0, 16'd20, 16'd3};
    for (int t = 0; t < 3; t++) begin
      int highs = 0, ticks = 0, nonzero = 0;
      stop_and_load(prs[t], duties[t], 5'd0, 1'b0);
      bus.EN_TMR = 1'b1;
      for (int i = 0; i < 22; i++) begin
        step();
        checks++;
        if ({bus.cnt_out, bus.pwm_out, bus.period_tick} !== {m_cnt, m_pwm, m_tick}) begin
          errors++;
          $display("FAIL extreme%0d cyc %0d: got %0d/%b/%b want %0d/%b/%b", t, i,
                   bus.cnt_out, bus.pwm_out, bus.period_tick, m_cnt, m_pwm, m_tick);
        end
        if (i >= 2) begin
          highs += int'(bus.pwm_out); ticks += int'(bus.period_tick);
          nonzero += int'(bus.cnt_out != 16'd0);
        end
      end
      checks++;
      if ((t == 0 && highs != 0) || (t == 1 && highs != 20) ||
          (t == 2 && (ticks != 20 || nonzero != 0))) begin
        errors++;
        $display("FAIL extreme%0d_shape: got highs=%0d ticks=%0d nonzero=%0d", t, highs, ticks, nonzero);
      end
    end
  endtask

  task automatic test_control();
    int n = 0, highs = 0, ticks = 0;
    stop_and_load(16'd9, 16'd3, 5'd0, 1'b0);
    bus.EN_TMR = 1'b1;
    while (bus.cnt_out != 16'd6 && n < 40) begin step(); n++; end
    bus.EN_TMR = 1'b0;
    step();
    checks++;
    if ({bus.cnt_out, bus.pwm_out, bus.period_tick} !== {16'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL stop: got %0d/%b/%b want 0/0/0", bus.cnt_out, bus.pwm_out, bus.period_tick);
    end
    bus.EN_TMR = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      highs += int'(bus.pwm_out); ticks += int'(bus.period_tick);
      checks++;
      if ({bus.cnt_out, bus.pwm_out, bus.period_tick} !== {m_cnt, m_pwm, m_tick}) begin
        errors++;
        $display("FAIL restart cyc %0d: got %0d/%b/%b want %0d/%b/%b", i,
                 bus.cnt_out, bus.pwm_out, bus.period_tick, m_cnt, m_pwm, m_tick);
      end
    end
    checks++;
    if (highs != 3 || ticks != 1) begin
      errors++;
      $display("FAIL restart_shape: got highs=%0d ticks=%0d want 3 1", highs, ticks);
    end
    n = 0;
    while (bus.cnt_out != 16'd4 && n < 40) begin step(); n++; end
    bus.soft_rst = 1'b1;
    step();
    bus.soft_rst = 1'b0;
    checks++;
    if ({bus.cnt_out, bus.pwm_out, bus.period_tick} !== {16'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL soft_rst: got %0d/%b/%b want 0/0/0", bus.cnt_out, bus.pwm_out, bus.period_tick);
    end
    for (int i = 0; i < 14; i++) begin
      step();
      checks++;
      if ({bus.cnt_out, bus.pwm_out, bus.period_tick} !== {m_cnt, m_pwm, m_tick}) begin
        errors++;
        $display("FAIL soft_resume cyc %0d: got %0d/%b/%b want %0d/%b/%b", i,
                 bus.cnt_out, bus.pwm_out, bus.period_tick, m_cnt, m_pwm, m_tick);
      end
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    stop_and_load(16'd9, 16'd3, 5'd0, 1'b0);
    bus.EN_TMR = 1'b1;
    while (bus.cnt_out != 16'd5 && n < 40) begin step(); n++; end
    #2 PRESETn = 1'b0;
    #1;
    model_zero();
    checks++;
    if ({bus.cnt_out, bus.pwm_out, bus.period_tick} !== {16'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got %0d/%b/%b want 0/0/0", bus.cnt_out, bus.pwm_out, bus.period_tick);
    end
    step(); step();
    PRESETn = 1'b1;
    for (int i = 0; i < 26; i++) begin
      step();
      checks++;
      if ({bus.cnt_out, bus.pwm_out, bus.period_tick} !== {m_cnt, m_pwm, m_tick}) begin
        errors++;
        $display("FAIL post_reset cyc %0d: got %0d/%b/%b want %0d/%b/%b", i,
                 bus.cnt_out, bus.pwm_out, bus.period_tick, m_cnt, m_pwm, m_tick);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      stop_and_load(16'($urandom_range(0, 7)), 16'($urandom_range(0, 10)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      bus.EN_TMR = 1'b1;
      for (int i = 0; i < 90; i++) begin
        step();
        checks++;
        if ({bus.cnt_out, bus.pwm_out, bus.period_tick} !== {m_cnt, m_pwm, m_tick}) begin
          errors++;
          $display("FAIL random r%0d cyc %0d: got %0d/%b/%b want %0d/%b/%b", r, i,
                   bus.cnt_out, bus.pwm_out, bus.period_tick, m_cnt, m_pwm, m_tick);
        end
        if ($urandom_range(0, 9) == 0) bus.duty_cycle_in = 16'($urandom_range(0, 10));
        if ($urandom_range(0, 9) == 0) bus.pr_in = 16'($urandom_range(0, 7));
        if ($urandom_range(0, 9) == 0) bus.prescale_value = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 29) == 0) bus.en_prescalar = ~bus.en_prescalar;
        bus.soft_rst = ($urandom_range(0, 39) == 0);
        bus.EN_TMR   = ($urandom_range(0, 49) != 0);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_no_prescale();
    test_divide2();
    test_shadowing();
    test_extremes();
    test_control();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
